// File: rtl/rom_load_rx_if.sv
// Host-link bundle for rom_load_rx: serial input plus the ROM write port and frame status.
// The loader drives the write port and status through the master modport.
interface rom_load_rx_if;
  logic        rx;
  logic [15:0] rom_write_addr;
  logic [7:0]  rom_write_data;
  logic        rom_write_en;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;

  modport master (
    input  rx,
    output rom_write_addr, rom_write_data, rom_write_en, busy, frame_ok, frame_err
  );

  modport slave (
    output rx,
    input  rom_write_addr, rom_write_data, rom_write_en, busy, frame_ok, frame_err
  );
endinterface

// File: rtl/rom_load_rx.sv
// 8N1 UART receiver and frame parser turning host frames (A5, ADDR_HI, ADDR_LO, LEN,
// data..., CSUM) into ROM write strobes for run-time game ROM loading.
module rom_load_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_CLKS = 120000
) (
  input  logic          clk,
  input  logic          rst,
  rom_load_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_AHI, P_ALO, P_LEN, P_DATA, P_CSUM} p_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle-high line level.
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t       r_state, r_state_d;
  logic [CW-1:0]   r_cnt, r_cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic [7:0]      rx_byte, rx_byte_d;
  logic            byte_valid, byte_valid_d;
  logic            abort, abort_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_IDLE;
      r_cnt      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      abort      <= 1'b0;
    end else begin
      r_state    <= r_state_d;
      r_cnt      <= r_cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      rx_byte    <= rx_byte_d;
      byte_valid <= byte_valid_d;
      abort      <= abort_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    r_state_d    = r_state;
    r_cnt_d      = r_cnt + 1'b1;
    bit_idx_d    = bit_idx;
    shift_d      = shift;
    rx_byte_d    = rx_byte;
    byte_valid_d = 1'b0;
    abort_d      = 1'b0;

    unique case (r_state)
      R_IDLE: begin
        r_cnt_d = '0;
        if (!rx_s) r_state_d = R_START;
      end
      R_START: begin
        // Mid-start-bit re-check rejects short low glitches.
        if (r_cnt == HALF_LAST) begin
          r_cnt_d   = '0;
          bit_idx_d = '0;
          r_state_d = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (r_cnt == BIT_LAST) begin
          r_cnt_d   = '0;
          shift_d   = {rx_s, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) r_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (r_cnt == BIT_LAST) begin
          r_cnt_d   = '0;
          r_state_d = R_IDLE;
          if (rx_s) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift;
          end else begin
            abort_d = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parser FSM
  // ---------------------------------------------------------------------------
  p_state_t      p_state, p_state_d;
  logic [15:0]   addr, addr_d;
  logic [8:0]    cnt, cnt_d;
  logic [7:0]    sum, sum_d;
  logic [TW-1:0] tmo, tmo_d;
  logic          busy_q, busy_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [15:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state   <= P_SYNC;
      addr      <= '0;
      cnt       <= '0;
      sum       <= '0;
      tmo       <= '0;
      busy_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      p_state   <= p_state_d;
      addr      <= addr_d;
      cnt       <= cnt_d;
      sum       <= sum_d;
      tmo       <= tmo_d;
      busy_q    <= busy_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    p_state_d = p_state;
    addr_d    = addr;
    cnt_d     = cnt;
    sum_d     = sum;
    tmo_d     = '0;
    busy_d    = busy_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // A received byte takes priority over a timeout expiring in the same cycle.
    if (byte_valid) begin
      unique case (p_state)
        P_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            p_state_d = P_AHI;
            busy_d    = 1'b1;
            sum_d     = '0;
          end
        end
        P_AHI: begin
          addr_d[15:8] = rx_byte;
          sum_d        = sum + rx_byte;
          p_state_d    = P_ALO;
        end
        P_ALO: begin
          addr_d[7:0] = rx_byte;
          sum_d       = sum + rx_byte;
          p_state_d   = P_LEN;
        end
        P_LEN: begin
          cnt_d     = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
          sum_d     = sum + rx_byte;
          p_state_d = P_DATA;
        end
        P_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr;
          wr_data_d = rx_byte;
          addr_d    = addr + 16'd1;
          sum_d     = sum + rx_byte;
          cnt_d     = cnt - 9'd1;
          if (cnt == 9'd1) p_state_d = P_CSUM;
        end
        P_CSUM: begin
          if ((sum + rx_byte) == 8'h00) ok_d = 1'b1;
          else                          err_d = 1'b1;
          busy_d    = 1'b0;
          p_state_d = P_SYNC;
        end
        default: p_state_d = P_SYNC;
      endcase
    end else if (p_state != P_SYNC) begin
      if (abort || tmo == TMO_LAST) begin
        err_d     = 1'b1;
        busy_d    = 1'b0;
        p_state_d = P_SYNC;
      end else begin
        tmo_d = tmo + 1'b1;
      end
    end
  end

  assign bus.rom_write_en   = wr_en_q;
  assign bus.rom_write_addr = wr_addr_q;
  assign bus.rom_write_data = wr_data_q;
  assign bus.busy           = busy_q;
  assign bus.frame_ok       = ok_q;
  assign bus.frame_err      = err_q;

endmodule
